// File: rtl/rv32_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rv32_pkg
//  Description : Shared RV32 constants and writeback-arbiter FSM encoding.
//  Revision    : 1.0
// ============================================================================
package rv32_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 1 << REG_ADDR_W;

    typedef enum logic [0:0] {
        ST_NORMAL = 1'b0,
        ST_FORCE  = 1'b1
    } arb_state_e;

    // A write to x0 is architecturally a no-op, so it never counts as a request.
    function automatic logic wb_req(input logic we, input logic [REG_ADDR_W-1:0] rd);
        return we && (rd != '0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/wb_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : wb_scoreboard
//  Description : Pending-writeback bitmap for MDU destinations plus decode stall lookup.
//  Revision    : 1.0
// ============================================================================
module wb_scoreboard
    import rv32_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  set_en_i,
    input  logic [REG_ADDR_W-1:0] set_idx_i,
    input  logic                  clr_en_i,
    input  logic [REG_ADDR_W-1:0] clr_idx_i,
    input  logic [REG_ADDR_W-1:0] rs1_i,
    input  logic [REG_ADDR_W-1:0] rs2_i,
    input  logic [REG_ADDR_W-1:0] rd_i,
    output logic [NUM_REGS-1:0]   pending_o,
    output logic                  stall_o
);

    logic [NUM_REGS-1:0] pending_q;
    logic [NUM_REGS-1:0] pending_d;

    generate
        for (genvar i = 0; i < NUM_REGS; i++) begin : g_bit
            if (i == 0) begin : g_zero
                assign pending_d[i] = 1'b0;
            end else begin : g_live
                // A new issue wins over a same-cycle retire of the same register.
                assign pending_d[i] = (set_en_i && (set_idx_i == REG_ADDR_W'(i))) ||
                                      (pending_q[i] && !(clr_en_i && (clr_idx_i == REG_ADDR_W'(i))));
            end
        end
    endgenerate

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    assign pending_o = pending_q;
    assign stall_o   = pending_q[rs1_i] | pending_q[rs2_i] | pending_q[rd_i];

endmodule
`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_wb_arbiter
//  Description : Single-port register-file writeback arbiter (pipeline vs MDU)
//                with starvation bubble and MDU destination scoreboard.
//  Revision    : 1.0
// ============================================================================
module regfile_wb_arbiter
    import rv32_pkg::*;
#(
    parameter int STARVE_LIMIT = 3
)
(
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  PIPE_WE,
    input  logic [REG_ADDR_W-1:0] PIPE_RD,
    input  logic [XLEN-1:0]       PIPE_DATA,
    input  logic                  MDU_VALID,
    input  logic [REG_ADDR_W-1:0] MDU_RD,
    input  logic [XLEN-1:0]       MDU_DATA,
    output logic                  MDU_READY,
    input  logic                  ISSUE_VALID,
    input  logic [REG_ADDR_W-1:0] ISSUE_RD,
    input  logic [REG_ADDR_W-1:0] DEC_RS1,
    input  logic [REG_ADDR_W-1:0] DEC_RS2,
    input  logic [REG_ADDR_W-1:0] DEC_RD,
    output logic                  HAZARD_STALL,
    output logic                  PIPE_HOLD,
    output logic                  WB_WRITE,
    output logic [REG_ADDR_W-1:0] WB_ADDR,
    output logic [XLEN-1:0]       WB_DATA,
    output logic [NUM_REGS-1:0]   PENDING,
    output logic                  PROTO_ERR
);

    localparam logic [3:0] c_STARVE_LIM = 4'(STARVE_LIMIT);

    arb_state_e            state_q;
    logic [3:0]            starve_q;
    logic [3:0]            starve_d;
    logic                  pipe_hold_q;
    logic                  wb_write_q;
    logic [REG_ADDR_W-1:0] wb_addr_q;
    logic [XLEN-1:0]       wb_data_q;
    logic                  proto_err_q;

    logic w_pipe_req;
    logic w_in_force;
    logic w_mdu_ready;
    logic w_mdu_xfer;
    logic w_pipe_grant;

    assign w_pipe_req   = wb_req(PIPE_WE, PIPE_RD);
    assign w_in_force   = (state_q == ST_FORCE);
    // Gating with RESET keeps the MDU from seeing a handshake while held in reset.
    assign w_mdu_ready  = RESET && (w_in_force || !w_pipe_req);
    assign w_mdu_xfer   = MDU_VALID && w_mdu_ready;
    assign w_pipe_grant = w_pipe_req && !w_in_force;

    always_comb begin
        starve_d = starve_q;
        if (!MDU_VALID || w_mdu_xfer) begin
            starve_d = 4'd0;
        end else if (starve_q != 4'hF) begin
            starve_d = starve_q + 4'd1;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q     <= ST_NORMAL;
            starve_q    <= 4'd0;
            pipe_hold_q <= 1'b0;
            wb_write_q  <= 1'b0;
            wb_addr_q   <= '0;
            wb_data_q   <= '0;
            proto_err_q <= 1'b0;
        end else begin
            starve_q <= starve_d;

            case (state_q)
                ST_NORMAL: begin
                    if (starve_d == c_STARVE_LIM) begin
                        state_q     <= ST_FORCE;
                        pipe_hold_q <= 1'b1;
                    end else begin
                        state_q     <= ST_NORMAL;
                        pipe_hold_q <= 1'b0;
                    end
                end
                ST_FORCE: begin
                    if (w_mdu_xfer || !MDU_VALID) begin
                        state_q     <= ST_NORMAL;
                        pipe_hold_q <= 1'b0;
                    end else begin
                        state_q     <= ST_FORCE;
                        pipe_hold_q <= 1'b1;
                    end
                end
            endcase

            if (w_pipe_grant) begin
                wb_write_q <= 1'b1;
                wb_addr_q  <= PIPE_RD;
                wb_data_q  <= PIPE_DATA;
            end else if (w_mdu_xfer && (MDU_RD != '0)) begin
                wb_write_q <= 1'b1;
                wb_addr_q  <= MDU_RD;
                wb_data_q  <= MDU_DATA;
            end else begin
                wb_write_q <= 1'b0;
                wb_addr_q  <= '0;
                wb_data_q  <= '0;
            end

            // A pipeline write during a bubble is dropped; flag it permanently.
            if (w_in_force && w_pipe_req) begin
                proto_err_q <= 1'b1;
            end
        end
    end

    wb_scoreboard u_scoreboard (
        .clk_i     (CLK),
        .rst_ni    (RESET),
        .set_en_i  (ISSUE_VALID),
        .set_idx_i (ISSUE_RD),
        .clr_en_i  (w_mdu_xfer),
        .clr_idx_i (MDU_RD),
        .rs1_i     (DEC_RS1),
        .rs2_i     (DEC_RS2),
        .rd_i      (DEC_RD),
        .pending_o (PENDING),
        .stall_o   (HAZARD_STALL)
    );

    assign MDU_READY = w_mdu_ready;
    assign PIPE_HOLD = pipe_hold_q;
    assign WB_WRITE  = wb_write_q;
    assign WB_ADDR   = wb_addr_q;
    assign WB_DATA   = wb_data_q;
    assign PROTO_ERR = proto_err_q;

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_regfile_wb_arbiter
//  Description : Self-checking bench for regfile_wb_arbiter against a
//                behavioural writeback/scoreboard model.
//  Revision    : 1.0
// ============================================================================
module tb_regfile_wb_arbiter;

    localparam int LIMIT = 3;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        PIPE_WE;
    logic [4:0]  PIPE_RD;
    logic [31:0] PIPE_DATA;
    logic        MDU_VALID;
    logic [4:0]  MDU_RD;
    logic [31:0] MDU_DATA;
    logic        MDU_READY;
    logic        ISSUE_VALID;
    logic [4:0]  ISSUE_RD;
    logic [4:0]  DEC_RS1, DEC_RS2, DEC_RD;
    logic        HAZARD_STALL;
    logic        PIPE_HOLD;
    logic        WB_WRITE;
    logic [4:0]  WB_ADDR;
    logic [31:0] WB_DATA;
    logic [31:0] PENDING;
    logic        PROTO_ERR;

    regfile_wb_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .CLK(CLK), .RESET(RESET),
        .PIPE_WE(PIPE_WE), .PIPE_RD(PIPE_RD), .PIPE_DATA(PIPE_DATA),
        .MDU_VALID(MDU_VALID), .MDU_RD(MDU_RD), .MDU_DATA(MDU_DATA),
        .MDU_READY(MDU_READY),
        .ISSUE_VALID(ISSUE_VALID), .ISSUE_RD(ISSUE_RD),
        .DEC_RS1(DEC_RS1), .DEC_RS2(DEC_RS2), .DEC_RD(DEC_RD),
        .HAZARD_STALL(HAZARD_STALL), .PIPE_HOLD(PIPE_HOLD),
        .WB_WRITE(WB_WRITE), .WB_ADDR(WB_ADDR), .WB_DATA(WB_DATA),
        .PENDING(PENDING), .PROTO_ERR(PROTO_ERR)
    );

    always #5 CLK = ~CLK;

    int n_pass  = 0;
    int n_total = 0;

    // Model: m_wait counts how long the MDU has been kept waiting; a bubble
    // is owed exactly when it has waited LIMIT cycles in a row.
    int          m_wait;
    bit [31:0]   m_pend;
    bit          m_wr;
    bit [4:0]    m_addr;
    bit [31:0]   m_data;
    bit          m_err;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        m_wait = 0; m_pend = '0; m_wr = 0; m_addr = '0; m_data = '0; m_err = 0;
    endtask

    task automatic model_edge();
        bit preq, bubble, ready, xfer;
        if (!RESET) return;
        preq   = PIPE_WE && (PIPE_RD != 0);
        bubble = (m_wait == LIMIT);
        ready  = bubble || !preq;
        xfer   = MDU_VALID && ready;
        if (preq && !bubble) begin
            m_wr = 1; m_addr = PIPE_RD; m_data = PIPE_DATA;
        end else if (xfer && MDU_RD != 0) begin
            m_wr = 1; m_addr = MDU_RD; m_data = MDU_DATA;
        end else begin
            m_wr = 0;
        end
        if (bubble && preq) m_err = 1;
        if (xfer) m_pend[MDU_RD] = 1'b0;
        if (ISSUE_VALID && ISSUE_RD != 0) m_pend[ISSUE_RD] = 1'b1;
        m_wait = (MDU_VALID && !ready) ? m_wait + 1 : 0;
    endtask

    task automatic cycle();
        @(posedge CLK);
        model_edge();
        #1;
    endtask

    always @(negedge CLK) begin
        bit preq, bubble;
        preq   = PIPE_WE && (PIPE_RD != 0);
        bubble = RESET && (m_wait == LIMIT);
        check("mdu_ready", MDU_READY, RESET && (bubble || !preq));
        check("hazard", HAZARD_STALL, m_pend[DEC_RS1] | m_pend[DEC_RS2] | m_pend[DEC_RD]);
        check("pipe_hold", PIPE_HOLD, bubble);
        check("wb_write", WB_WRITE, m_wr);
        if (m_wr) begin
            check("wb_addr", WB_ADDR, m_addr);
            check("wb_data", WB_DATA, m_data);
        end
        check("pending", PENDING, m_pend);
        check("proto_err", PROTO_ERR, m_err);
    end

    task automatic idle_inputs();
        PIPE_WE = 0; PIPE_RD = 0; PIPE_DATA = 0;
        MDU_VALID = 0; MDU_RD = 0; MDU_DATA = 0;
        ISSUE_VALID = 0; ISSUE_RD = 0;
        DEC_RS1 = 0; DEC_RS2 = 0; DEC_RD = 0;
    endtask

    task automatic do_reset();
        RESET = 0; model_reset();
        cycle(); cycle();
        RESET = 1;
    endtask

    initial begin
        RESET = 0; model_reset(); idle_inputs();
        cycle();
        check("rst_wb_write", WB_WRITE, 0);
        check("rst_pending", PENDING, 0);
        check("rst_ready", MDU_READY, 0);
        check("rst_hold", PIPE_HOLD, 0);
        check("rst_err", PROTO_ERR, 0);
        cycle();
        RESET = 1;

        // Simple pipeline write
        PIPE_WE = 1; PIPE_RD = 5; PIPE_DATA = 32'hDEADBEEF;
        cycle();
        PIPE_WE = 0;
        check("pipe_wr_en", WB_WRITE, 1);
        check("pipe_wr_addr", WB_ADDR, 5);
        check("pipe_wr_data", WB_DATA, 32'hDEADBEEF);

        // Issue x7, then decode reads it
        ISSUE_VALID = 1; ISSUE_RD = 7;
        cycle();
        ISSUE_VALID = 0; DEC_RS2 = 7;
        #1 check("stall_x7", HAZARD_STALL, 1);
        check("pend_x7", PENDING, 32'h0000_0080);
        MDU_VALID = 1; MDU_RD = 7; MDU_DATA = 32'h0000_1234;
        #1 check("ready_idle", MDU_READY, 1);
        cycle();
        MDU_VALID = 0;
        #1 check("pend_x7_clr", PENDING[7], 0);
        check("stall_x7_clr", HAZARD_STALL, 0);
        check("mdu_wr_addr", WB_ADDR, 7);
        DEC_RS2 = 0;

        // Starvation -> bubble
        PIPE_WE = 1; PIPE_DATA = 32'h1111_0000;
        MDU_VALID = 1; MDU_RD = 12; MDU_DATA = 32'hC0FFEE00;
        for (int i = 0; i < LIMIT; i++) begin
            PIPE_RD = 5'(3 + i);
            #1 check("starve_ready0", MDU_READY, 0);
            cycle();
        end
        PIPE_WE = 0;
        #1 check("force_hold", PIPE_HOLD, 1);
        check("force_ready", MDU_READY, 1);
        cycle();
        MDU_VALID = 0;
        check("force_wr_addr", WB_ADDR, 12);
        check("force_wr_data", WB_DATA, 32'hC0FFEE00);
        check("force_exit", PIPE_HOLD, 0);
        cycle();

        // Pipeline write during bubble
        PIPE_WE = 1; PIPE_RD = 20; PIPE_DATA = 32'h2020_2020;
        MDU_VALID = 1; MDU_RD = 13; MDU_DATA = 32'hABCD0013;
        for (int i = 0; i < LIMIT; i++) cycle();
        #1 check("err_hold", PIPE_HOLD, 1);
        cycle();
        check("err_set", PROTO_ERR, 1);
        check("err_wr_addr", WB_ADDR, 13);
        check("err_wr_data", WB_DATA, 32'hABCD0013);
        PIPE_WE = 0; MDU_VALID = 0;
        cycle(); cycle();
        check("err_sticky", PROTO_ERR, 1);

        // x0 corner cases and same-cycle set/clear
        ISSUE_VALID = 1; ISSUE_RD = 0; MDU_VALID = 1; MDU_RD = 0; MDU_DATA = 32'h5555_5555;
        cycle();
        check("x0_pend", PENDING, 0);
        check("x0_wr", WB_WRITE, 0);
        ISSUE_RD = 9; MDU_RD = 9;
        cycle();
        check("setclr_x9", PENDING, 32'h0000_0200);
        ISSUE_VALID = 0;
        cycle();
        MDU_VALID = 0;

        // Randomised traffic, with occasional resets
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
            end
            PIPE_WE     = ($urandom_range(0, 1) == 1);
            PIPE_RD     = 5'($urandom_range(0, 31));
            PIPE_DATA   = $urandom;
            MDU_VALID   = ($urandom_range(0, 9) < 6);
            MDU_RD      = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            MDU_DATA    = $urandom;
            ISSUE_VALID = ($urandom_range(0, 3) == 0);
            ISSUE_RD    = 5'($urandom_range(0, 31));
            DEC_RS1     = 5'($urandom_range(0, 31));
            DEC_RS2     = 5'($urandom_range(0, 31));
            DEC_RD      = 5'($urandom_range(0, 31));
            cycle();
        end

        // Asynchronous reset in the middle of a bubble
        idle_inputs();
        do_reset();
        ISSUE_VALID = 1; ISSUE_RD = 7;
        cycle();
        ISSUE_RD = 10;
        cycle();
        ISSUE_VALID = 0; DEC_RS1 = 7;
        PIPE_WE = 1; PIPE_RD = 4; MDU_VALID = 1; MDU_RD = 2; MDU_DATA = 32'h0BAD_0002;
        for (int i = 0; i < LIMIT; i++) cycle();
        PIPE_WE = 0;
        #1 check("pre_rst_hold", PIPE_HOLD, 1);
        check("pre_rst_pend", PENDING, 32'h0000_0480);
        check("pre_rst_stall", HAZARD_STALL, 1);
        RESET = 0; model_reset();
        #1 check("arst_hold", PIPE_HOLD, 0);
        check("arst_ready", MDU_READY, 0);
        check("arst_pend", PENDING, 0);
        check("arst_stall", HAZARD_STALL, 0);
        check("arst_wr", WB_WRITE, 0);
        check("arst_addr", WB_ADDR, 0);
        check("arst_data", WB_DATA, 0);
        check("arst_err", PROTO_ERR, 0);
        cycle();
        RESET = 1;
        idle_inputs();
        PIPE_WE = 1; PIPE_RD = 1; PIPE_DATA = 32'h0000_00A1;
        cycle();
        PIPE_WE = 0;
        check("post_rst_wr", WB_DATA, 32'h0000_00A1);
        cycle(); cycle();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 3: consecutive stalled MDU cycles before a forced pipeline bubble (legal range 1..15).
REQ-002 SHALL have port CLK, input, 1: single clock; all state updates on posedge.
REQ-003 SHALL have port RESET, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have ports PIPE_WE / PIPE_RD / PIPE_DATA, input, 1/5/32: single-cycle pipeline writeback request.
REQ-005 SHALL have ports MDU_VALID / MDU_RD / MDU_DATA, input, 1/5/32: multi-cycle MUL/DIV writeback request.
REQ-006 SHALL have port MDU_READY, output, 1: MDU request accepted this cycle (transfer = MDU_VALID & MDU_READY).
REQ-007 SHALL have ports ISSUE_VALID / ISSUE_RD, input, 1/5: MDU operation issued from decode, destination rd.
REQ-008 SHALL have ports DEC_RS1 / DEC_RS2 / DEC_RD, input, 5 each: register indices of the instruction in decode.
REQ-009 SHALL have port HAZARD_STALL, output, 1: combinational; decode instruction touches a pending register.
REQ-010 SHALL have port PIPE_HOLD, output, 1: registered; the pipeline shall present no writeback this cycle.
REQ-011 SHALL have ports WB_WRITE / WB_ADDR / WB_DATA, output, 1/5/32: registered drive of the register file's WRITE/INADDRESS/IN.
REQ-012 SHALL have ports PENDING, output, 32 (scoreboard bitmap), and PROTO_ERR, output, 1 (sticky).

Function
REQ-013 SHALL treat a pipeline request as PIPE_WE=1 with PIPE_RD!=0; PIPE_RD=0 is no request.
REQ-014 SHALL in state NORMAL grant the pipeline request over MDU; MDU_READY = !(pipeline request).
REQ-015 SHALL register the granted write: WB_WRITE/WB_ADDR/WB_DATA valid exactly 1 cycle after grant; WB_WRITE=0 in cycles with no grant.
REQ-016 SHALL accept an MDU transfer with MDU_RD=0, clear nothing, and keep WB_WRITE=0.
REQ-017 SHALL keep a 4-bit starve counter: +1 each cycle MDU_VALID & !MDU_READY, cleared on any MDU transfer or MDU_VALID=0.
REQ-018 SHALL implement FSM NORMAL -> FORCE when the counter reaches STARVE_LIMIT; FORCE -> NORMAL on the MDU transfer or when MDU_VALID drops.
REQ-019 SHALL assert PIPE_HOLD and MDU_READY=1 for every cycle in FORCE.
REQ-020 SHALL, on a pipeline request during FORCE, grant the MDU, drop the pipeline write, and set PROTO_ERR (cleared only by reset).
REQ-021 SHALL set PENDING[ISSUE_RD] on ISSUE_VALID with ISSUE_RD!=0, and clear PENDING[MDU_RD] on an MDU transfer.
REQ-022 SHALL keep the bit at 1 when set and clear target the same index in one cycle.
REQ-023 SHALL hold PENDING[0]=0 permanently.
REQ-024 SHALL drive HAZARD_STALL = PENDING[DEC_RS1] | PENDING[DEC_RS2] | PENDING[DEC_RD], using the pre-update bitmap.
REQ-025 SHALL not clear PENDING for a pipeline write to a pending rd; that write is still performed.

Reset
REQ-026 SHALL while RESET=0 force state NORMAL, counter 0, PENDING=0, WB_WRITE=0, WB_ADDR=0, WB_DATA=0, PIPE_HOLD=0, PROTO_ERR=0.
REQ-027 SHALL drive MDU_READY=0 during reset, and resume in NORMAL on the first posedge after release.
REQ-028 SHALL discard an in-flight registered write or FORCE episode when reset is asserted mid-operation.

Structure
REQ-029 SHALL place the FSM state encoding (NORMAL, FORCE), XLEN=32 and REG_ADDR_W=5 in shared package rv32_pkg.
REQ-030 SHALL implement the 32-bit scoreboard as sub-module wb_scoreboard (set/clear ports, PENDING output, stall lookup).

Verification
REQ-031 SHALL cover: PIPE_WE=1, RD=5, DATA=0xDEADBEEF, MDU idle -> next cycle WB_WRITE=1, WB_ADDR=5, WB_DATA=0xDEADBEEF.
REQ-032 SHALL cover: ISSUE_VALID, ISSUE_RD=7, then DEC_RS2=7 -> HAZARD_STALL=1; MDU transfer RD=7 -> PENDING[7]=0 and HAZARD_STALL=0 next cycle.
REQ-033 SHALL cover: MDU_VALID held with PIPE_WE=1 for 3 cycles -> cycle 4: PIPE_HOLD=1, MDU_READY=1; MDU written 1 cycle later; state back to NORMAL.
REQ-034 SHALL cover: PIPE_WE=1 while PIPE_HOLD=1 -> PROTO_ERR=1 (sticky), pipeline write absent from WB_*.
REQ-035 SHALL cover: ISSUE_RD=0 and MDU_RD=0 transfer -> PENDING stays 0, WB_WRITE stays 0; same-cycle set/clear of x9 -> PENDING[9]=1.
REQ-036 SHALL cover: RESET=0 asserted mid-FORCE with PENDING=0x00000480 -> all outputs 0 immediately (asynchronous), not waiting for CLK.
